// File: rtl/gf_pow.sv
// Sequential GF(2^M) power / inverse unit using right-to-left square-and-multiply.
// Optional macro GF_POW_EARLY_EXIT_EN retires as soon as the remaining exponent is zero.
module gf_pow #(
  parameter int unsigned M    = 8,
  parameter logic [M:0]  POLY = 9'h11D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_base,
  input  logic [M-1:0] in_exp,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out
);

  localparam int unsigned CNT_W = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // x^(2^M-2) is the multiplicative inverse of x in GF(2^M)
  localparam logic [M-1:0]     INV_EXP  = {{(M-1){1'b1}}, 1'b0};
  localparam logic [M-1:0]     ONE      = M'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

  logic [1:0]       state_q, state_d;
  logic [M-1:0]     b_q, b_d;
  logic [M-1:0]     e_q, e_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     out_q, out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [M-1:0]     acc_step;
  logic [M-1:0]     b_sq;
  logic [M-1:0]     e_shift;
  logic             last_iter;

  // Shift-and-add multiply, MSB first, reducing by POLY on each shift
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY[M-1:0] : '0);
      if (a[i]) p = p ^ b;
    end
    return p;
  endfunction

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    e_d         = e_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    acc_step = e_q[0] ? gf_mul(acc_q, b_q) : acc_q;
    b_sq     = gf_mul(b_q, b_q);
    e_shift  = e_q >> 1;
`ifdef GF_POW_EARLY_EXIT_EN
    last_iter = (cnt_q == CNT_LAST) || (e_shift == '0);
`else
    last_iter = (cnt_q == CNT_LAST);
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          b_d        = in_base;
          e_d        = in_inv ? INV_EXP : in_exp;
          acc_d      = ONE;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        b_d   = b_sq;
        e_d   = e_shift;
        acc_d = acc_step;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (last_iter) begin
          out_d       = acc_step;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // Retire only; a new request is taken one edge later
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      e_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      e_q         <= e_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_gf_pow.sv
// Scoreboard bench for gf_pow (M=8, POLY=0x11D); expected latency follows GF_POW_EARLY_EXIT_EN.
module tb_gf_pow;

  localparam int unsigned M    = 8;
  localparam logic [M:0]  POLY = 9'h11D;
`ifdef GF_POW_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_base;
  logic [M-1:0] in_exp;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out;

  gf_pow #(.M(M), .POLY(POLY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_exp    (in_exp),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    int         lat;
    int         acc;
    logic [7:0] base;
    bit         invchk;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_acc = 0;
  bit         lat_seen = 1'b0;
  logic [7:0] alpha_tbl [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
      if (a[i]) p = p ^ b;
    end
    return p;
  endfunction

  function automatic int exp_lat(input logic [7:0] e, input bit inv);
    logic [7:0] eff;
    eff = inv ? 8'hFE : e;
    if (!EARLY) return 8;
    for (int i = 7; i >= 0; i--) if (eff[i]) return i + 1;
    return 1;
  endfunction

  // Issue one request, push its expectation at the accept edge, then scramble inputs
  task automatic send(input logic [7:0] base, input logic [7:0] e, input bit inv,
                      input logic [7:0] expv, input bit invchk);
    int budget;
    exp_t ent;
    @(negedge clk);
    in_valid = 1'b1;
    in_base  = base;
    in_exp   = e;
    in_inv   = inv;
    budget   = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    last_acc   = cyc + 1;
    ent.val    = expv;
    ent.lat    = exp_lat(e, inv);
    ent.acc    = last_acc;
    ent.base   = base;
    ent.invchk = invchk;
    q.push_back(ent);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base  = 8'hA5;
    in_exp   = 8'h5A;
    in_inv   = ~inv;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: latency on first valid cycle, result on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !lat_seen) begin
        lat_seen = 1'b1;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%0h with no request outstanding (t=%0t)", out, $time);
        end else begin
          check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        end
      end
      if (out_valid && out_ready) begin
        lat_seen = 1'b0;
        if (q.size() > 0) begin
          exp_t ent;
          ent = q.pop_front();
          check("result", 32'(out), 32'(ent.val));
          if (ent.invchk) check("inv_product", 32'(gmul(ent.base, out)), 32'd1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         h;
    int         budget;

    a = 8'h01;
    for (int i = 0; i < 256; i++) begin
      alpha_tbl[i] = a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    end

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_base   = 8'h00;
    in_exp    = 8'h00;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    send(8'h02, 8'h08, 1'b0, 8'h1D, 1'b0);
    send(8'h02, 8'hFF, 1'b0, 8'h01, 1'b0);
    send(8'h03, 8'h02, 1'b0, 8'h05, 1'b0);
    send(8'h1D, 8'h00, 1'b1, 8'h83, 1'b1);
    send(8'h00, 8'h00, 1'b0, 8'h01, 1'b0);
    send(8'h00, 8'h05, 1'b0, 8'h00, 1'b0);
    send(8'h00, 8'h33, 1'b1, 8'h00, 1'b0);
    send(8'h02, 8'h00, 1'b1, 8'h8E, 1'b1);
    send(8'h02, 8'h01, 1'b0, 8'h02, 1'b0);
    send(8'h02, 8'h80, 1'b0, 8'h85, 1'b0);
    wait_drain();

    // Backpressure: hold the result in DONE with a second request pending
    out_ready = 1'b0;
    send(8'h02, 8'h08, 1'b0, 8'h1D, 1'b0);
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_base  = 8'h03;
    in_exp   = 8'h02;
    in_inv   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out", 32'(out), 32'h1D);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    h = cyc + 1;
    send(8'h03, 8'h02, 1'b0, 8'h05, 1'b0);
    check("bp_accept_edge", 32'(last_acc), 32'(h + 1));
    wait_drain();

    // Reset mid-BUSY, between clock edges
    send(8'h02, 8'hFF, 1'b0, 8'h01, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    lat_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h02, 8'h08, 1'b0, 8'h1D, 1'b0);
    wait_drain();

    // Sweep all exponents of alpha against the software table
    for (int e = 0; e < 256; e++) begin
      send(8'h02, 8'(e), 1'b0, alpha_tbl[e], 1'b0);
    end
    wait_drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
